// File: rtl/lpc_host_pkg.sv
// Shared LPC host definitions: LAD codes, host FSM states and request payload.
package lpc_host_pkg;

  localparam int unsigned LAD_W  = 4;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  // LAD field encodings
  localparam logic [LAD_W-1:0] LPC_START      = 4'b0000;
  localparam logic [LAD_W-1:0] LPC_IO_READ    = 4'b0000;
  localparam logic [LAD_W-1:0] LPC_IO_WRITE   = 4'b0010;
  localparam logic [LAD_W-1:0] LPC_SYNC_READY = 4'b0000;
  localparam logic [LAD_W-1:0] LPC_SYNC_SWAIT = 4'b0101;
  localparam logic [LAD_W-1:0] LPC_SYNC_LWAIT = 4'b0110;
  localparam logic [LAD_W-1:0] LPC_SYNC_ERROR = 4'b1010;
  localparam logic [LAD_W-1:0] LPC_ABORT      = 4'b1111;

  // Number of LFRAME#-low clocks in the abort sequence
  localparam logic [2:0] LPC_ABORT_CLKS = 3'd4;

  typedef enum logic [4:0] {
    LPC_HST_IDLE,
    LPC_HST_START,
    LPC_HST_CYCTYPE,
    LPC_HST_ADDR1,
    LPC_HST_ADDR2,
    LPC_HST_ADDR3,
    LPC_HST_ADDR4,
    LPC_HST_DATA_WR1,
    LPC_HST_DATA_WR2,
    LPC_HST_TAR1,
    LPC_HST_TAR2,
    LPC_HST_SYNC,
    LPC_HST_DATA_RD1,
    LPC_HST_DATA_RD2,
    LPC_HST_FTAR1,
    LPC_HST_FTAR2,
    LPC_HST_ABORT
  } lpc_hst_state_e;

  // Request captured from the local requester
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } lpc_req_t;

endpackage

// File: rtl/lpc_host.sv
// LPC host initiator: single-byte I/O read/write with SYNC wait, error,
// no-response and timeout handling. LAD/LFRAME# launched on negedge,
// LAD sampled on posedge.
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 64,
  parameter int unsigned NO_RESP_CLKS = 3
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic [7:0]  rdata_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned WAIT_W = $clog2(SYNC_TIMEOUT) + 1;
  localparam int unsigned NR_W   = $clog2(NO_RESP_CLKS) + 1;

  lpc_hst_state_e    r_state;
  lpc_hst_state_e    w_next;
  lpc_req_t          r_req;
  logic              r_err_lat;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [NR_W-1:0]   r_nr_cnt;
  logic [2:0]        r_abt_cnt;
  logic [3:0]        r_rd_lo;
  logic              r_lad_oe;
  logic [3:0]        r_lad_out;

  logic [3:0]        w_lad_in;
  logic              w_sync_ready;
  logic              w_sync_err;
  logic              w_sync_wait;
  logic              w_sync_none;
  logic              w_wait_hit;
  logic              w_nr_hit;
  logic              w_lframe;
  logic              w_lad_oe;
  logic [3:0]        w_lad_out;
  logic              w_done;
  logic              w_busy;
  logic              w_err;

  assign lad_bus  = r_lad_oe ? r_lad_out : 4'bzzzz;
  assign w_lad_in = lad_bus;

  // SYNC code decode and limit detection for the current sample
  assign w_sync_ready = (w_lad_in == LPC_SYNC_READY);
  assign w_sync_err   = (w_lad_in == LPC_SYNC_ERROR);
  assign w_sync_wait  = (w_lad_in == LPC_SYNC_SWAIT) || (w_lad_in == LPC_SYNC_LWAIT);
  assign w_sync_none  = (w_lad_in == LPC_ABORT);
  assign w_wait_hit   = (32'(r_wait_cnt) + 32'd1) >= SYNC_TIMEOUT;
  assign w_nr_hit     = (32'(r_nr_cnt) + 32'd1) >= NO_RESP_CLKS;

  // State register
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) r_state <= LPC_HST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      LPC_HST_IDLE:     if (req_i) w_next = LPC_HST_START;
      LPC_HST_START:    w_next = LPC_HST_CYCTYPE;
      LPC_HST_CYCTYPE:  w_next = LPC_HST_ADDR1;
      LPC_HST_ADDR1:    w_next = LPC_HST_ADDR2;
      LPC_HST_ADDR2:    w_next = LPC_HST_ADDR3;
      LPC_HST_ADDR3:    w_next = LPC_HST_ADDR4;
      LPC_HST_ADDR4:    w_next = r_req.wr ? LPC_HST_DATA_WR1 : LPC_HST_TAR1;
      LPC_HST_DATA_WR1: w_next = LPC_HST_DATA_WR2;
      LPC_HST_DATA_WR2: w_next = LPC_HST_TAR1;
      LPC_HST_TAR1:     w_next = LPC_HST_TAR2;
      LPC_HST_TAR2:     w_next = LPC_HST_SYNC;
      LPC_HST_SYNC: begin
        if (w_sync_ready || w_sync_err) begin
          w_next = r_req.wr ? LPC_HST_FTAR1 : LPC_HST_DATA_RD1;
        end else if (w_sync_wait) begin
          if (w_wait_hit) w_next = LPC_HST_ABORT;
        end else if (w_sync_none) begin
          if (w_nr_hit) w_next = LPC_HST_ABORT;
        end else begin
          w_next = LPC_HST_ABORT;
        end
      end
      LPC_HST_DATA_RD1: w_next = LPC_HST_DATA_RD2;
      LPC_HST_DATA_RD2: w_next = LPC_HST_FTAR1;
      LPC_HST_FTAR1:    w_next = LPC_HST_FTAR2;
      LPC_HST_FTAR2:    w_next = LPC_HST_IDLE;
      LPC_HST_ABORT:    if (r_abt_cnt == LPC_ABORT_CLKS) w_next = LPC_HST_IDLE;
      default:          w_next = LPC_HST_IDLE;
    endcase
  end

  // Output decode: values launched onto the bus at the next negedge
  always_comb begin
    w_lframe  = 1'b1;
    w_lad_oe  = 1'b0;
    w_lad_out = LPC_ABORT;
    w_done    = 1'b0;
    w_busy    = (r_state != LPC_HST_IDLE);
    w_err     = err_o;
    case (r_state)
      LPC_HST_START: begin
        w_lframe  = 1'b0;
        w_lad_oe  = 1'b1;
        w_lad_out = LPC_START;
        w_err     = 1'b0;
      end
      LPC_HST_CYCTYPE: begin
        w_lad_oe  = 1'b1;
        w_lad_out = r_req.wr ? LPC_IO_WRITE : LPC_IO_READ;
      end
      LPC_HST_ADDR1:    begin w_lad_oe = 1'b1; w_lad_out = r_req.addr[15:12]; end
      LPC_HST_ADDR2:    begin w_lad_oe = 1'b1; w_lad_out = r_req.addr[11:8];  end
      LPC_HST_ADDR3:    begin w_lad_oe = 1'b1; w_lad_out = r_req.addr[7:4];   end
      LPC_HST_ADDR4:    begin w_lad_oe = 1'b1; w_lad_out = r_req.addr[3:0];   end
      LPC_HST_DATA_WR1: begin w_lad_oe = 1'b1; w_lad_out = r_req.wdata[3:0]; end
      LPC_HST_DATA_WR2: begin w_lad_oe = 1'b1; w_lad_out = r_req.wdata[7:4]; end
      LPC_HST_TAR1:     begin w_lad_oe = 1'b1; w_lad_out = LPC_ABORT;         end
      LPC_HST_FTAR2: begin
        w_done = 1'b1;
        w_err  = r_err_lat;
      end
      LPC_HST_ABORT: begin
        if (r_abt_cnt < LPC_ABORT_CLKS) begin
          w_lframe = 1'b0;
          w_lad_oe = 1'b1;
        end else begin
          w_done = 1'b1;
          w_err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus and status outputs launched on the falling edge
  always_ff @(negedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      lframe_o  <= 1'b1;
      r_lad_oe  <= 1'b0;
      r_lad_out <= LPC_ABORT;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      lframe_o  <= w_lframe;
      r_lad_oe  <= w_lad_oe;
      r_lad_out <= w_lad_out;
      done_o    <= w_done;
      busy_o    <= w_busy;
      err_o     <= w_err;
    end
  end

  // Request capture, SYNC counters, error latch and read data capture
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_req      <= '0;
      r_err_lat  <= 1'b0;
      r_wait_cnt <= '0;
      r_nr_cnt   <= '0;
      r_abt_cnt  <= '0;
      r_rd_lo    <= '0;
      rdata_o    <= '0;
    end else begin
      if (r_state == LPC_HST_IDLE && req_i) begin
        r_req     <= '{wr: wr_i, addr: addr_i, wdata: wdata_i};
        r_err_lat <= 1'b0;
      end
      if (r_state == LPC_HST_TAR2) begin
        r_wait_cnt <= '0;
        r_nr_cnt   <= '0;
      end
      if (r_state == LPC_HST_SYNC) begin
        if (w_sync_wait) begin
          if (r_wait_cnt != '1) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          r_nr_cnt <= '0;
        end
        if (w_sync_none && r_nr_cnt != '1) r_nr_cnt <= r_nr_cnt + NR_W'(1);
        if (w_sync_err) r_err_lat <= 1'b1;
      end
      if (r_state == LPC_HST_DATA_RD1) r_rd_lo <= w_lad_in;
      if (r_state == LPC_HST_DATA_RD2) rdata_o <= {w_lad_in, r_rd_lo};
      if (r_state == LPC_HST_ABORT) r_abt_cnt <= r_abt_cnt + 3'd1;
      else                          r_abt_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Self-checking bench for lpc_host: a target model on LAD plus a per-clock
// expected-bus schedule derived from the LPC cycle rules.
module tb_lpc_host;

  localparam int unsigned SYNC_TIMEOUT = 64;
  localparam int unsigned NO_RESP_CLKS = 3;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic        lframe_o;
  tri1  [3:0]  lad;
  logic        req_i;
  logic        wr_i;
  logic [15:0] addr_i;
  logic [7:0]  wdata_i;
  logic        busy_o;
  logic [7:0]  rdata_o;
  logic        done_o;
  logic        err_o;

  logic        tgt_oe;
  logic [3:0]  tgt_val;

  assign lad = tgt_oe ? tgt_val : 4'bzzzz;

  always #5 clk_i = ~clk_i;

  lpc_host #(.SYNC_TIMEOUT(SYNC_TIMEOUT), .NO_RESP_CLKS(NO_RESP_CLKS)) dut (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .lframe_o(lframe_o),
    .lad_bus (lad),
    .req_i   (req_i),
    .wr_i    (wr_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .rdata_o (rdata_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  typedef struct {
    logic       lframe;
    logic [3:0] lad;
    logic       tgt_oe;
    logic [3:0] tgt_val;
    logic       done;
  } step_t;

  step_t      tbl[$];
  logic [3:0] sync_q[$];
  logic [7:0] exp_rdata;
  logic       exp_err;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic lf, input logic [3:0] ld,
                               input logic oe, input logic [3:0] tv, input logic dn);
    step_t s;
    s.lframe = lf; s.lad = ld; s.tgt_oe = oe; s.tgt_val = tv; s.done = dn;
    tbl.push_back(s);
  endfunction

  // Reference schedule: one entry per LPC clock from START to the done clock.
  // An absent target (code F) is modelled as a released, pulled-up bus.
  function automatic void build(input logic wr, input logic [15:0] a,
                                input logic [7:0] wd, input logic [7:0] rd);
    int unsigned waits = 0;
    int unsigned nores = 0;
    logic        err = 1'b0;
    logic        ok  = 1'b0;
    logic        abt = 1'b0;
    tbl.delete();
    push(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
    push(1'b1, wr ? 4'h2 : 4'h0, 1'b0, 4'h0, 1'b0);
    for (int i = 3; i >= 0; i--) push(1'b1, 4'((a >> (4 * i)) & 16'hF), 1'b0, 4'h0, 1'b0);
    if (wr) begin
      push(1'b1, wd[3:0], 1'b0, 4'h0, 1'b0);
      push(1'b1, wd[7:4], 1'b0, 4'h0, 1'b0);
    end
    push(1'b1, 4'hF, 1'b0, 4'h0, 1'b0);
    push(1'b1, 4'hF, 1'b0, 4'h0, 1'b0);
    foreach (sync_q[i]) begin
      if (ok || abt) break;
      push(1'b1, sync_q[i], sync_q[i] != 4'hF, sync_q[i], 1'b0);
      case (sync_q[i])
        4'h0: ok = 1'b1;
        4'hA: begin ok = 1'b1; err = 1'b1; end
        4'h5, 4'h6: begin
          waits++;
          nores = 0;
          if (waits >= SYNC_TIMEOUT) abt = 1'b1;
        end
        4'hF: begin
          nores++;
          if (nores >= NO_RESP_CLKS) abt = 1'b1;
        end
        default: abt = 1'b1;
      endcase
    end
    if (ok) begin
      if (!wr) begin
        push(1'b1, rd[3:0], 1'b1, rd[3:0], 1'b0);
        push(1'b1, rd[7:4], 1'b1, rd[7:4], 1'b0);
        exp_rdata = rd;
      end
      push(1'b1, 4'hF, 1'b1, 4'hF, 1'b0);
      push(1'b1, 4'hF, 1'b0, 4'h0, 1'b1);
      exp_err = err;
    end else begin
      for (int i = 0; i < 4; i++) push(1'b0, 4'hF, 1'b0, 4'h0, 1'b0);
      push(1'b1, 4'hF, 1'b0, 4'h0, 1'b1);
      exp_err = 1'b1;
    end
  endfunction

  task automatic run_txn(input string name, input logic wr, input logic [15:0] a,
                         input logic [7:0] wd, input logic [7:0] rd);
    build(wr, a, wd, rd);
    @(negedge clk_i);
    req_i = 1'b1; wr_i = wr; addr_i = a; wdata_i = wd;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk_i);
      tgt_oe = tbl[k].tgt_oe; tgt_val = tbl[k].tgt_val;
      @(posedge clk_i); #1;
      chk($sformatf("%s c%0d lframe", name, k + 1), 16'(lframe_o), 16'(tbl[k].lframe));
      chk($sformatf("%s c%0d lad", name, k + 1), 16'(lad), 16'(tbl[k].lad));
      chk($sformatf("%s c%0d done", name, k + 1), 16'(done_o), 16'(tbl[k].done));
      chk($sformatf("%s c%0d busy", name, k + 1), 16'(busy_o), 16'(1'b1));
    end
    chk($sformatf("%s err", name), 16'(err_o), 16'(exp_err));
    chk($sformatf("%s rdata", name), 16'(rdata_o), 16'(exp_rdata));
    @(negedge clk_i);
    tgt_oe = 1'b0;
    @(posedge clk_i); #1;
    chk($sformatf("%s idle busy", name), 16'(busy_o), 16'(1'b0));
    chk($sformatf("%s idle done", name), 16'(done_o), 16'(1'b0));
    chk($sformatf("%s idle lframe", name), 16'(lframe_o), 16'(1'b1));
    chk($sformatf("%s idle lad", name), 16'(lad), 16'(4'hF));
    chk($sformatf("%s err held", name), 16'(err_o), 16'(exp_err));
  endtask

  initial begin
    nrst_i = 1'b0; req_i = 1'b0; wr_i = 1'b0; addr_i = '0; wdata_i = '0;
    tgt_oe = 1'b0; tgt_val = '0;
    exp_rdata = 8'h00; exp_err = 1'b0;
    #12;
    chk("rst lframe", 16'(lframe_o), 16'(1'b1));
    chk("rst lad", 16'(lad), 16'(4'hF));
    chk("rst busy", 16'(busy_o), 16'(1'b0));
    chk("rst done", 16'(done_o), 16'(1'b0));
    chk("rst err", 16'(err_o), 16'(1'b0));
    chk("rst rdata", 16'(rdata_o), 16'(8'h00));
    @(posedge clk_i); #2;
    nrst_i = 1'b1;

    // Zero-wait write 0x5A to 0x0FF0
    sync_q = '{4'h0};
    run_txn("wr0ff0", 1'b1, 16'h0FF0, 8'h5A, 8'h00);

    // Read 0x0C00 with five long waits before READY
    sync_q = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h0};
    run_txn("rd0c00", 1'b0, 16'h0C00, 8'h00, 8'hA5);

    // No target present
    sync_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    run_txn("noresp", 1'b0, 16'h1234, 8'h00, 8'h77);

    // Target stuck in long wait past the timeout
    sync_q.delete();
    for (int i = 0; i < 100; i++) sync_q.push_back(4'h6);
    run_txn("timeout", 1'b0, 16'h0080, 8'h00, 8'h11);

    // SYNC error still completes the read
    sync_q = '{4'hA};
    run_txn("syncerr", 1'b0, 16'h2E2F, 8'h00, 8'h3C);

    // Unknown SYNC code aborts
    sync_q = '{4'h5, 4'h3};
    run_txn("badsync", 1'b1, 16'h4321, 8'hC3, 8'h00);

    // Short wait clears the no-response run
    sync_q = '{4'hF, 4'hF, 4'h5, 4'hF, 4'hF, 4'h0};
    run_txn("nrclear", 1'b1, 16'h8001, 8'h96, 8'h00);

    // Randomized cycles
    for (int t = 0; t < 10; t++) begin
      int unsigned n;
      sync_q.delete();
      n = $urandom_range(0, 6);
      for (int i = 0; i < int'(n); i++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 4)      sync_q.push_back(r[0] ? 4'h5 : 4'h6);
        else if (r < 8) sync_q.push_back(4'hF);
        else            sync_q.push_back(4'($urandom_range(0, 15)));
      end
      sync_q.push_back(($urandom_range(0, 3) == 0) ? 4'hA : 4'h0);
      run_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 16'($urandom),
              8'($urandom), 8'($urandom));
    end

    // Reset asserted mid-cycle during ADDR2
    @(negedge clk_i);
    req_i = 1'b1; wr_i = 1'b1; addr_i = 16'h1234; wdata_i = 8'h99;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk_i);
    #2;
    chk("mid addr2 lad", 16'(lad), 16'(4'h2));
    nrst_i = 1'b0;
    #1;
    chk("mid lframe", 16'(lframe_o), 16'(1'b1));
    chk("mid lad", 16'(lad), 16'(4'hF));
    chk("mid busy", 16'(busy_o), 16'(1'b0));
    chk("mid done", 16'(done_o), 16'(1'b0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("mid hold done %0d", i), 16'(done_o), 16'(1'b0));
    end
    #2;
    nrst_i = 1'b1;
    exp_rdata = 8'h00; exp_err = 1'b0;
    chk("mid rdata", 16'(rdata_o), 16'(exp_rdata));
    sync_q = '{4'h5, 4'h0};
    run_txn("postrst", 1'b0, 16'h0C00, 8'h00, 8'h5E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lpc_host.md
Name: lpc_host

Overview:
- LPC host-side initiator. Issues single-byte LPC I/O Read and I/O Write cycles on LAD[3:0]/LFRAME# for a local requester; lpc_periph is the target.
- Handles SYNC wait states, SYNC error, no-response detection, wait timeout, and the abort sequence.
- Used as the host model in simulation benches and as a host core on FPGA test platforms.

Parameters:
- SYNC_TIMEOUT, 64: max consecutive clocks of SYNC short/long wait (0101/0110) before abort.
- NO_RESP_CLKS, 3: max consecutive clocks of LAD=1111 in SYNC before abort (no target present).

Ports:
- clk_i  in  1  LPC clock.
- nrst_i  in  1  reset, asynchronous, active-low.
- lframe_o  out  1  LFRAME#, active low.
- lad_bus  inout  4  LAD bus; tri-stated when not driven by host.
- req_i  in  1  start request, sampled on posedge while idle.
- wr_i  in  1  1 = I/O Write, 0 = I/O Read; sampled with req_i.
- addr_i  in  16  I/O address; sampled with req_i.
- wdata_i  in  8  write data; sampled with req_i.
- busy_o  out  1  cycle in progress; req_i ignored while high.
- rdata_o  out  8  read data; valid when done_o pulses for a read.
- done_o  out  1  one-clock pulse at end of every cycle, including aborted ones.
- err_o  out  1  status qualifier valid with done_o: SYNC error, timeout or no response.

Behaviour:
- Reset values: lframe_o=1, LAD tri-stated, busy_o=0, done_o=0, err_o=0, rdata_o=0x00. FSM goes to IDLE and both counters clear.
- Timing: LAD/LFRAME# driven and changed on negedge clk_i; LAD sampled on posedge clk_i. This is the mirror of the peripheral's timing.
- Request latch: req_i=1 in IDLE at a posedge latches wr_i/addr_i/wdata_i and sets busy_o. The following negedge begins START.
- START: lframe_o=0, LAD=0000, one clock.
- CYCTYPE: lframe_o=1. LAD=0000 for read, 0010 for write.
- ADDR1..ADDR4: addr nibbles [15:12], [11:8], [7:4], [3:0].
- Write only, DATA_WR1/DATA_WR2: wdata[3:0], then wdata[7:4].
- TAR1: host drives 1111. TAR2: host releases LAD.
- SYNC: host samples LAD each posedge.
  - 0000 READY: read goes to DATA_RD1; write goes to FTAR1.
  - 0101 or 0110: stay in SYNC; wait_cnt++. If wait_cnt reaches SYNC_TIMEOUT, go to ABORT.
  - 1010 ERROR: set err latch, then continue as READY.
  - 1111: noresp_cnt++. If it reaches NO_RESP_CLKS, go to ABORT.
  - Any other code: go to ABORT.
  - wait_cnt and noresp_cnt clear on entry to SYNC. A valid wait code clears noresp_cnt.
- DATA_RD1/DATA_RD2: capture rdata[3:0], then rdata[7:4].
- FTAR1/FTAR2: LAD released (target drives 1111 then floats). In FTAR2, done_o=1 and busy_o drops at the following negedge.
- Zero-wait cycle length is 13 clocks from START through FTAR2, for both read and write.
- ABORT: lframe_o=0 and LAD=1111 for 4 clocks, then lframe_o=1 for 1 clock. done_o=1 and err_o=1 on that last clock, then IDLE. rdata_o is unchanged on an aborted read.
- err_o is held from the done_o pulse until the next accepted request. done_o never asserts while busy_o=0.
- Counter widths: $clog2(param)+1 bits each; counters saturate and never wrap.
- Reset mid-cycle: immediately lframe_o=1, LAD released, no done_o pulse.
- req_i held high across done_o: the next cycle starts from IDLE, with a minimum of one idle clock (lframe_o=1, LAD floating) between cycles.

Decomposition:
- Shared lpc_defines.v gains host state encodings LPC_HST_IDLE..LPC_HST_ABORT.
- It also gains LPC_SYNC_SWAIT (0101), LPC_SYNC_ERROR (1010) and LPC_ABORT (1111) where missing.
- Reuse existing LPC_START, LPC_IO_READ, LPC_IO_WRITE, LPC_SYNC_READY, LPC_SYNC_LWAIT.
- No sub-module: one FSM and two counters in a single module.

Test Plan:
- Write 0x5A to 0x0FF0 against lpc_periph with lpc_wr_done tied 1:
  - LAD sequence 0000, 0010, 0, F, F, 0, A, 5, then SYNC READY.
  - Peripheral sees lpc_addr_o=0x0FF0 and lpc_data_o=0x5A.
  - done_o at clock 13 with err_o=0.
- Read from 0x0C00, periph lpc_data_i=0xA5 with lpc_data_rd delayed 5 clocks:
  - Host observes LWAIT SYNCs, then READY.
  - rdata_o=0xA5, err_o=0, total cycle 13+N clocks.
- No target (LAD pulled up) on read 0x1234:
  - 3 SYNC clocks of 1111, then ABORT with LFRAME# low for 4 clocks and LAD=1111.
  - done_o=1, err_o=1, rdata_o unchanged.
- Target model holding 0110 for 100 clocks with SYNC_TIMEOUT=64:
  - ABORT starts after 64 wait clocks; err_o=1.
- Target model returns 1010 then data 0x3C:
  - rdata_o=0x3C, err_o=1, no abort.
- nrst_i asserted during ADDR2:
  - lframe_o=1 and LAD=zzzz before the next edge, busy_o=0, no done_o.
  - A new request afterwards completes normally.
